// File: rtl/rom_pkg.sv
// rom_pkg
//   Shared types and helpers for the burst-reading ROM.
//   - rom_state_e : burst engine FSM states
//   - rom_mode_e  : address sequencing mode of the active burst
//   - is_pow2_blk : true when len+1 is a power of two (wrap is legal)
//   - next_addr   : address of the beat that follows address a
package rom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rom_state_e;

  typedef enum logic {
    LINEAR = 1'b0,
    WRAP   = 1'b1
  } rom_mode_e;

  // Output buffer entries; one ROM read may be in flight on top of these.
  localparam int unsigned SKID_DEPTH = 2;

  function automatic logic is_pow2_blk(input int unsigned len);
    return ((len + 32'd1) & len) == 32'd0;
  endfunction

  // WRAP is only ever latched when len+1 is a power of two, so len doubles
  // as the in-block mask. Linear mode wraps at depth; an out-of-range start
  // keeps counting until the address field itself rolls over to 0.
  function automatic int unsigned next_addr(input int unsigned a,
                                            input int unsigned depth,
                                            input int unsigned len,
                                            input rom_mode_e   mode,
                                            input int unsigned addr_bits);
    if (mode == WRAP)
      return (a & ~len) | ((a + 32'd1) & len);
    if (a == depth - 32'd1)
      return 32'd0;
    return (a + 32'd1) & ((32'd1 << addr_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/rom_array.sv
// rom_array
//   Registered-output read-only memory, WIDTH x DEPTH. Data is not reset.
//   Ports:
//     CLK      clock, read registered on posedge
//     rd_en    capture a new word this cycle; otherwise rd_data holds
//     rd_addr  word address; addresses >= DEPTH read as 0
//     rd_data  registered read data
module rom_array #(
  parameter int    WIDTH     = 9,
  parameter int    DEPTH     = 32,
  parameter int    ADDR_BITS = 5,
  parameter string INIT_FILE = "my_ROM.mif"
) (
  input  logic                 CLK,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam bit HAS_INIT = (INIT_FILE != "");

  // The image is elaborated from the same rule that generates INIT_FILE
  // (word i = 3*i), so the simulated table matches the programmed device.
  (* ram_init_file = INIT_FILE *) logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = HAS_INIT ? WIDTH'(i * 3) : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd_data <= (32'(rd_addr) < 32'(DEPTH)) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//   Synchronous ROM with a burst-read engine: one request (addr, len, wrap)
//   yields REQ_LEN+1 words on a valid/ready stream with full backpressure.
//
//   state | meaning
//   IDLE  | accepting a request (REQ_READY=1)
//   READ  | issuing one ROM read per cycle while buffer credit allows
//   DRAIN | all reads issued, waiting for the last beat to be accepted
//
//   Ports:
//     CLK, RESET_N          clock, synchronous active-low reset
//     REQ_VALID/REQ_READY   request handshake
//     REQ_ADDR/LEN/WRAP     first address, beats-1, wrap-in-block mode
//     DOUT_VALID/READY      output handshake
//     DOUT_DATA/LAST/ERR    word, final-beat flag, out-of-range flag
//     BUSY                  burst active or output holding data
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int    WIDTH     = 9,
  parameter int    DEPTH     = 32,
  parameter int    ADDR_BITS = 5,
  parameter string INIT_FILE = "my_ROM.mif",
  parameter int    MAX_BURST = 16,
  parameter int    LEN_BITS  = $clog2(MAX_BURST)
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [ADDR_BITS-1:0] REQ_ADDR,
  input  logic [LEN_BITS-1:0]  REQ_LEN,
  input  logic                 REQ_WRAP,
  output logic                 DOUT_VALID,
  input  logic                 DOUT_READY,
  output logic [WIDTH-1:0]     DOUT_DATA,
  output logic                 DOUT_LAST,
  output logic                 DOUT_ERR,
  output logic                 BUSY
);

  rom_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [LEN_BITS-1:0]  rem_q;      // reads still to issue, minus 1
  rom_mode_e            mode_q, mode_d;

  logic                 issue, pop, addr_err, drain_done;
  logic [2:0]           credit_used;

  logic [WIDTH-1:0]     rom_q;
  logic                 fl_q, fl_last_q, fl_err_q;   // read in flight

  logic [WIDTH-1:0]     sk_data [SKID_DEPTH];
  logic                 sk_last [SKID_DEPTH];
  logic                 sk_err  [SKID_DEPTH];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           occ_q;

  assign REQ_READY  = (state_q == IDLE);
  assign DOUT_VALID = (occ_q != 2'd0);
  assign DOUT_DATA  = DOUT_VALID ? sk_data[rd_ptr_q] : '0;
  assign DOUT_LAST  = DOUT_VALID & sk_last[rd_ptr_q];
  assign DOUT_ERR   = DOUT_VALID & sk_err[rd_ptr_q];
  assign BUSY       = (state_q != IDLE) || DOUT_VALID;

  assign pop      = DOUT_VALID && DOUT_READY;
  assign addr_err = 32'(addr_q) >= 32'(DEPTH);
  assign mode_d   = (REQ_WRAP && is_pow2_blk(32'(REQ_LEN))) ? WRAP : LINEAR;

  // Credit counts the buffer occupancy left after this cycle's pop, so a
  // consumer that is always ready sees back-to-back beats.
  assign credit_used = {1'b0, occ_q} + {2'b00, fl_q} - {2'b00, pop};

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    drain_done = !fl_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));
    case (state_q)
      IDLE: begin
        if (REQ_VALID) state_d = READ;
      end
      READ: begin
        if (credit_used < 3'(SKID_DEPTH)) begin
          issue = 1'b1;
          if (rem_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      addr_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      mode_q    <= LINEAR;
      fl_q      <= 1'b0;
      fl_last_q <= 1'b0;
      fl_err_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        sk_data[i] <= '0;
        sk_last[i] <= 1'b0;
        sk_err[i]  <= 1'b0;
      end
    end else begin
      if (state_q == IDLE && REQ_VALID) begin
        addr_q <= REQ_ADDR;
        len_q  <= REQ_LEN;
        rem_q  <= REQ_LEN;
        mode_q <= mode_d;
      end
      if (issue) begin
        addr_q    <= ADDR_BITS'(next_addr(32'(addr_q), DEPTH, 32'(len_q),
                                          mode_q, ADDR_BITS));
        rem_q     <= rem_q - LEN_BITS'(1);
        fl_last_q <= (rem_q == '0);
        fl_err_q  <= addr_err;
      end
      fl_q <= issue;
      if (fl_q) begin
        sk_data[wr_ptr_q] <= fl_err_q ? '0 : rom_q;
        sk_last[wr_ptr_q] <= fl_last_q;
        sk_err[wr_ptr_q]  <= fl_err_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, fl_q} - {1'b0, pop};
    end
  end

  rom_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .CLK     (CLK),
    .rd_en   (issue),
    .rd_addr (addr_q),
    .rd_data (rom_q)
  );

endmodule
